intr_ctrl: RTL and testbench

Prioritised interrupt controller in front of the control unit's single `interrupt` input. Supports NUM_SRC external sources with these features:
- synchronises each source and edge-detects it into a pending latch;
- applies per-source masks and the global I flag;
- presents one request plus a vector to the control unit and tracks the in-service period until RETID/RETIE.

It owns the global interrupt-enable flag, which is driven by the control unit's `i_set`/`i_clr` strobes.

---
 rtl/intr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl -- prioritised interrupt controller for the control unit (CU).
//
// Each raw line goes through a two-flop synchroniser. A rising edge of the
// synchronised value sets that source's pending bit. Pending bits are
// qualified by the per-source mask and by the global I flag. The lowest
// eligible index wins. The controller then raises one request and holds the
// granted id/vector stable until the CU acknowledges it. It stays in service
// until RETID/RETIE (iret).
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   irq_in       raw asynchronous interrupt lines, active high
//   src_mask     per-source enable (1 = enabled), does not gate latching
//   pend_clr     one-cycle software clear of pending bits
//   i_set/i_clr  CU strobes that set/clear the I flag (clear wins)
//   int_ack      CU interrupt-state strobe, honoured only while requesting
//   iret         CU RETID/RETIE strobe, honoured only while in service
//   interrupt    registered request to the CU
//   int_vector   PC vector of the granted source (VECTOR_BASE + id)
//   int_id       index of the granted source
//   pending      pending latch contents
//   i_flag       global interrupt enable
//   in_service   high from acknowledge until iret
// ---------------------------------------------------------------------------
module intr_ctrl #(
  parameter int          NUM_SRC     = 4,
  parameter int          ID_W        = 2,
  parameter logic [9:0]  VECTOR_BASE = 10'h3F8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               i_set,
  input  logic               i_clr,
  input  logic               int_ack,
  input  logic               iret,
  output logic               interrupt,
  output logic [9:0]         int_vector,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               i_flag,
  output logic               in_service
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_sync1, r_sync2, r_hist;
  logic [NUM_SRC-1:0] r_pending, w_pending_nxt;
  logic               r_i_flag, w_i_flag_nxt;
  logic               r_interrupt, w_interrupt_nxt;
  logic               r_in_service, w_in_service_nxt;
  logic [ID_W-1:0]    r_int_id;
  logic [9:0]         r_int_vector;

  logic [NUM_SRC-1:0] w_edge;
  logic               w_ack_req;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_eligible;
  logic               w_win_found;
  logic [ID_W-1:0]    w_win_id;
  logic               w_load_id;

  // ---------------- synchroniser and edge detect -------------------------
  // NOTE: the synchroniser and history flops reset to ones, so a line that is
  // already high when reset is released does not look like a rising edge.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {NUM_SRC{1'b1}};
      r_sync2 <= {NUM_SRC{1'b1}};
      r_hist  <= {NUM_SRC{1'b1}};
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_hist;

  // ---------------- pending latch and I flag -----------------------------
  assign w_ack_req = int_ack && (r_state == ST_REQ);
  assign w_ack_clr = w_ack_req ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_int_id)
                               : '0;

  // A new edge is ORed in last, so it wins over any clear in the same cycle.
  assign w_pending_nxt = (r_pending & ~(pend_clr | w_ack_clr)) | w_edge;

  always_comb begin
    // NOTE: a default assignment first keeps this block from inferring a latch.
    w_i_flag_nxt = r_i_flag;
    if (i_set)                 w_i_flag_nxt = 1'b1;
    if (i_clr || w_ack_req)    w_i_flag_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_i_flag  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_i_flag  <= w_i_flag_nxt;
    end
  end

  // ---------------- priority select --------------------------------------
  // Bits being cleared this cycle are excluded, so a request is not raised for
  // a source that software is withdrawing.
  assign w_eligible = r_pending & src_mask & ~pend_clr & {NUM_SRC{r_i_flag}};

  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    // Scan downwards so that the lowest index is the last one written.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(k);
      end
    end
  end

  // ---------------- FSM: state register ----------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_interrupt  <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_interrupt  <= w_interrupt_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  // ---------------- FSM: next state --------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // An i_clr in the same cycle would leave the request up with I=0.
        if (w_win_found && !i_clr) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (int_ack)
          w_state_nxt = ST_SERVICE;
        else if (i_clr || !w_pending_nxt[r_int_id])
          w_state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (iret) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered one edge later) -------------
  always_comb begin
    w_interrupt_nxt  = (w_state_nxt == ST_REQ);
    w_in_service_nxt = (w_state_nxt == ST_SERVICE);
    w_load_id        = (r_state == ST_IDLE) && (w_state_nxt == ST_REQ);
  end

  // The grant is captured only on entry to REQ and then held stable, even if
  // a higher-priority source becomes pending meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_id     <= '0;
      r_int_vector <= VECTOR_BASE;
    end else if (w_load_id) begin
      r_int_id     <= w_win_id;
      r_int_vector <= VECTOR_BASE + {{(10-ID_W){1'b0}}, w_win_id};
    end
  end

  assign interrupt  = r_interrupt;
  assign in_service = r_in_service;
  assign int_id     = r_int_id;
  assign int_vector = r_int_vector;
  assign pending    = r_pending;
  assign i_flag     = r_i_flag;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl -- directed, table-driven bench for intr_ctrl (4 sources,
// VECTOR_BASE 10'h3F8). Table rows give the inputs for one clock edge and the
// outputs expected just after it. Hand-written sequences cover masking,
// withdrawal, ack during service, clear/edge collision and reset.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq_in, src_mask, pend_clr;
  logic       i_set, i_clr, int_ack, iret;
  logic       interrupt;
  logic [9:0] int_vector;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic       i_flag, in_service;

  int total = 0;
  int bad   = 0;

  intr_ctrl #(.NUM_SRC(4), .ID_W(2), .VECTOR_BASE(10'h3F8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .src_mask   (src_mask),
    .pend_clr   (pend_clr),
    .i_set      (i_set),
    .i_clr      (i_clr),
    .int_ack    (int_ack),
    .iret       (iret),
    .interrupt  (interrupt),
    .int_vector (int_vector),
    .int_id     (int_id),
    .pending    (pending),
    .i_flag     (i_flag),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       set, clr, ack, ret;
    logic       e_int;
    logic [1:0] e_id;
    logic [9:0] e_vec;
    logic [3:0] e_pend;
    logic       e_if, e_svc;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic e_int,
                           input logic [1:0] e_id, input logic [9:0] e_vec,
                           input logic [3:0] e_pend, input logic e_if,
                           input logic e_svc);
    check({tag, " interrupt"},  32'(interrupt),  32'(e_int));
    check({tag, " int_id"},     32'(int_id),     32'(e_id));
    check({tag, " int_vector"}, 32'(int_vector), 32'(e_vec));
    check({tag, " pending"},    32'(pending),    32'(e_pend));
    check({tag, " i_flag"},     32'(i_flag),     32'(e_if));
    check({tag, " in_service"}, 32'(in_service), 32'(e_svc));
  endtask

  initial begin
    // irq, set, clr, ack, iret | int, id, vector, pending, i_flag, in_service
    // Single pulse on source 2, full ack/iret cycle.
    tbl[0]  = '{4'b0100, 0, 0, 0, 0, 0, 2'd0, 10'h3F8, 4'b0000, 1, 0};
    tbl[1]  = '{4'b0000, 0, 0, 0, 0, 0, 2'd0, 10'h3F8, 4'b0000, 1, 0};
    tbl[2]  = '{4'b0000, 0, 0, 0, 0, 0, 2'd0, 10'h3F8, 4'b0100, 1, 0};
    tbl[3]  = '{4'b0000, 0, 0, 0, 0, 1, 2'd2, 10'h3FA, 4'b0100, 1, 0};
    tbl[4]  = '{4'b0000, 0, 0, 0, 0, 1, 2'd2, 10'h3FA, 4'b0100, 1, 0};
    tbl[5]  = '{4'b0000, 0, 0, 1, 0, 0, 2'd2, 10'h3FA, 4'b0000, 0, 1};
    tbl[6]  = '{4'b0000, 0, 0, 0, 0, 0, 2'd2, 10'h3FA, 4'b0000, 0, 1};
    tbl[7]  = '{4'b0000, 1, 0, 0, 1, 0, 2'd2, 10'h3FA, 4'b0000, 1, 0};
    tbl[8]  = '{4'b0000, 0, 0, 0, 0, 0, 2'd2, 10'h3FA, 4'b0000, 1, 0};
    // Simultaneous edges on sources 3 and 1: 1 first, then 3.
    tbl[9]  = '{4'b1010, 0, 0, 0, 0, 0, 2'd2, 10'h3FA, 4'b0000, 1, 0};
    tbl[10] = '{4'b1010, 0, 0, 0, 0, 0, 2'd2, 10'h3FA, 4'b0000, 1, 0};
    tbl[11] = '{4'b1010, 0, 0, 0, 0, 0, 2'd2, 10'h3FA, 4'b1010, 1, 0};
    tbl[12] = '{4'b1010, 0, 0, 0, 0, 1, 2'd1, 10'h3F9, 4'b1010, 1, 0};
    tbl[13] = '{4'b1010, 0, 0, 1, 0, 0, 2'd1, 10'h3F9, 4'b1000, 0, 1};
    tbl[14] = '{4'b1010, 1, 0, 0, 1, 0, 2'd1, 10'h3F9, 4'b1000, 1, 0};
    tbl[15] = '{4'b1010, 0, 0, 0, 0, 1, 2'd3, 10'h3FB, 4'b1000, 1, 0};
    tbl[16] = '{4'b1010, 0, 0, 1, 0, 0, 2'd3, 10'h3FB, 4'b0000, 0, 1};
    tbl[17] = '{4'b0000, 1, 0, 0, 1, 0, 2'd3, 10'h3FB, 4'b0000, 1, 0};

    // ---- reset with source 0 held high ----
    reset_n  = 1'b0;
    irq_in   = 4'b0001;
    src_mask = 4'b1111;
    pend_clr = 4'b0000;
    i_set = 0; i_clr = 0; int_ack = 0; iret = 0;
    #12;
    check_all("reset", 0, 2'd0, 10'h3F8, 4'b0000, 0, 0);
    reset_n = 1'b1;

    // ---- line high through reset produces no edge ----
    i_set = 1;
    tick(1);
    i_set = 0;
    check("t1 i_flag set", 32'(i_flag), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("t1 pending c%0d", i),   32'(pending),   32'd0);
      check($sformatf("t1 interrupt c%0d", i), 32'(interrupt), 32'd0);
    end
    irq_in = 4'b0000;
    tick(3);
    check("t1 no edge on fall", 32'(pending), 32'd0);

    // ---- table-driven vectors ----
    for (int r = 0; r < 18; r++) begin
      irq_in  = tbl[r].irq;
      i_set   = tbl[r].set;
      i_clr   = tbl[r].clr;
      int_ack = tbl[r].ack;
      iret    = tbl[r].ret;
      tick(1);
      check_all($sformatf("row%0d", r), tbl[r].e_int, tbl[r].e_id,
                tbl[r].e_vec, tbl[r].e_pend, tbl[r].e_if, tbl[r].e_svc);
    end
    irq_in = 0; i_set = 0; i_clr = 0; int_ack = 0; iret = 0;

    // ---- masking ----
    i_clr = 1;
    tick(1);
    i_clr = 0;
    check("t4 i_flag cleared", 32'(i_flag), 32'd0);
    irq_in = 4'b0001;
    tick(1);
    irq_in = 4'b0000;
    tick(2);
    check("t4 pending0 set", 32'(pending), 32'b0001);
    tick(3);
    check("t4 no req i_flag=0", 32'(interrupt), 32'd0);
    src_mask = 4'b1110;
    i_set = 1;
    tick(1);
    i_set = 0;
    tick(3);
    check("t4 no req masked", 32'(interrupt), 32'd0);
    check("t4 i_flag on", 32'(i_flag), 32'd1);
    src_mask = 4'b1111;
    tick(1);
    check("t4 req after unmask", 32'(interrupt), 32'd1);
    check("t4 id", 32'(int_id), 32'd0);
    check("t4 vector", 32'(int_vector), 32'h3F8);

    // ---- withdrawal via i_clr ----
    i_clr = 1;
    tick(1);
    i_clr = 0;
    check_all("t5 withdrawn", 0, 2'd0, 10'h3F8, 4'b0001, 0, 0);
    tick(2);
    check("t5 stays low", 32'(interrupt), 32'd0);
    i_set = 1;
    tick(1);
    i_set = 0;
    check("t5 not yet", 32'(interrupt), 32'd0);
    tick(1);
    check_all("t5 re-request", 1, 2'd0, 10'h3F8, 4'b0001, 1, 0);
    int_ack = 1;
    tick(1);
    int_ack = 0;
    check_all("t5 service", 0, 2'd0, 10'h3F8, 4'b0000, 0, 1);

    // ---- edge plus ack during service ----
    irq_in = 4'b0001;
    tick(1);
    irq_in = 4'b0000;
    tick(1);
    int_ack = 1;
    tick(1);
    int_ack = 0;
    check_all("t6 ack ignored", 0, 2'd0, 10'h3F8, 4'b0001, 0, 1);
    tick(3);
    check("t6 no nesting", 32'(interrupt), 32'd0);
    iret = 1; i_set = 1;
    tick(1);
    iret = 0; i_set = 0;
    check_all("t6 iret", 0, 2'd0, 10'h3F8, 4'b0001, 1, 0);
    tick(1);
    check_all("t6 served", 1, 2'd0, 10'h3F8, 4'b0001, 1, 0);

    // ---- pend_clr withdraws the granted source; edge beats clear ----
    pend_clr = 4'b0001;
    tick(1);
    pend_clr = 4'b0000;
    check_all("t7 pend_clr drop", 0, 2'd0, 10'h3F8, 4'b0000, 1, 0);
    irq_in = 4'b0010;
    tick(1);
    irq_in = 4'b0000;
    tick(1);
    pend_clr = 4'b0010;
    tick(1);
    pend_clr = 4'b0000;
    check("t7 edge wins", 32'(pending), 32'b0010);
    check("t7 idle", 32'(interrupt), 32'd0);
    tick(1);
    check_all("t7 req src1", 1, 2'd1, 10'h3F9, 4'b0010, 1, 0);

    // ---- reset mid-operation ----
    #2;
    reset_n = 1'b0;
    #1;
    check_all("t8 async reset", 0, 2'd0, 10'h3F8, 4'b0000, 0, 0);
    reset_n = 1'b1;
    tick(2);
    check("t8 idle after reset", 32'(interrupt), 32'd0);
    check("t8 pending lost", 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
